// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  // Controller states: normal issue, one-cycle post-branch flush, memory freeze.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  // Zero register: writes to it are discarded, so it never creates a dependency.
  localparam logic [4:0] XZR = 5'd31;

  // Default width of the performance counters.
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and flag-dependency detection between decode and execute.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] DecRn,
  input  logic [4:0] DecRm,
  input  logic       DecUsesRn,
  input  logic       DecUsesRm,
  input  logic       DecFlagRead,
  input  logic [4:0] ExRd,
  input  logic       ExMemRead,
  input  logic       ExRegWrite,
  input  logic       ExFlagWrite,
  output logic       load_use,
  output logic       flag_hazard
);

  logic rn_match;
  logic rm_match;

  // A load result is not available until after memory, so a dependent read in decode must wait.
  always_comb begin
    rn_match    = DecUsesRn && (DecRn == ExRd);
    rm_match    = DecUsesRm && (DecRm == ExRd);
    load_use    = ExMemRead && ExRegWrite && (ExRd != XZR) && (rn_match || rm_match);
    flag_hazard = DecFlagRead && ExFlagWrite;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall, flush and freeze sequencing plus performance counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       DecRn,
  input  logic [4:0]       DecRm,
  input  logic             DecUsesRn,
  input  logic             DecUsesRm,
  input  logic             DecFlagRead,
  input  logic [4:0]       ExRd,
  input  logic             ExMemRead,
  input  logic             ExRegWrite,
  input  logic             ExFlagWrite,
  input  logic             MemBrTaken,
  input  logic             MemBusy,
  output logic             PcWrite,
  output logic             IfIdWrite,
  output logic             IdExBubble,
  output logic             Flush,
  output logic             Freeze,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  state_t state, state_nxt;
  logic   load_use;
  logic   flag_hazard;

  hazard_detect u_hazard_detect (
    .DecRn       (DecRn),
    .DecRm       (DecRm),
    .DecUsesRn   (DecUsesRn),
    .DecUsesRm   (DecUsesRm),
    .DecFlagRead (DecFlagRead),
    .ExRd        (ExRd),
    .ExMemRead   (ExMemRead),
    .ExRegWrite  (ExRegWrite),
    .ExFlagWrite (ExFlagWrite),
    .load_use    (load_use),
    .flag_hazard (flag_hazard)
  );

  // State register; reset abandons any stall, flush or freeze in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state and Mealy outputs, causes taken in priority order busy > branch > hazards.
  always_comb begin
    state_nxt  = RUN;
    PcWrite    = 1'b1;
    IfIdWrite  = 1'b1;
    IdExBubble = 1'b0;
    Flush      = 1'b0;
    Freeze     = 1'b0;
    if (reset) begin
      // Hold fetch and clear the pipe while reset is asserted.
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
      Flush     = 1'b1;
    end else if (MemBusy) begin
      // Memory stalls everything; a coincident taken branch stays held in the frozen memory stage.
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
      Freeze    = 1'b1;
      state_nxt = FREEZE;
    end else begin
      case (state)
        FLUSH: begin
          // Decode holds a bubble this cycle, so hazards against it are meaningless.
          state_nxt = RUN;
        end
        default: begin
          // RUN, and FREEZE once memory is ready, behave identically.
          if (MemBrTaken) begin
            Flush     = 1'b1;
            state_nxt = FLUSH;
          end else if (load_use || flag_hazard) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating counts of bubble insertions and flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (IdExBubble && (StallCount != {CNT_W{1'b1}})) StallCount <= StallCount + 1'b1;
      if (Flush && (FlushCount != {CNT_W{1'b1}}))      FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  DecRn, DecRm, ExRd;
  logic        DecUsesRn, DecUsesRm, DecFlagRead;
  logic        ExMemRead, ExRegWrite, ExFlagWrite;
  logic        MemBrTaken, MemBusy;
  logic        PcWrite, IfIdWrite, IdExBubble, Flush, Freeze;
  logic [15:0] StallCount, FlushCount;

  int checks   = 0;
  int failures = 0;
  int exp_stall;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .DecRn(DecRn), .DecRm(DecRm), .DecUsesRn(DecUsesRn), .DecUsesRm(DecUsesRm),
    .DecFlagRead(DecFlagRead), .ExRd(ExRd), .ExMemRead(ExMemRead),
    .ExRegWrite(ExRegWrite), .ExFlagWrite(ExFlagWrite),
    .MemBrTaken(MemBrTaken), .MemBusy(MemBusy),
    .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IdExBubble(IdExBubble),
    .Flush(Flush), .Freeze(Freeze), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    DecRn = 0; DecRm = 0; ExRd = 0;
    DecUsesRn = 0; DecUsesRm = 0; DecFlagRead = 0;
    ExMemRead = 0; ExRegWrite = 0; ExFlagWrite = 0;
    MemBrTaken = 0; MemBusy = 0;
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait to the falling edge to sample the combinational outputs.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ExMemRead = 1; ExRegWrite = 1; ExRd = r; DecRn = r; DecUsesRn = 1;
  endtask

  task automatic ctrl(input string tag, input logic pc, input logic ifid,
                      input logic bub, input logic fl, input logic fz);
    chk({tag, ".pc"},   PcWrite,    pc);
    chk({tag, ".ifid"}, IfIdWrite,  ifid);
    chk({tag, ".bub"},  IdExBubble, bub);
    chk({tag, ".fl"},   Flush,      fl);
    chk({tag, ".fz"},   Freeze,     fz);
  endtask

  initial begin
    clr();
    reset = 1;
    #3;
    ctrl("rst", 0, 0, 0, 1, 0);
    chk("rst.sc", StallCount, 0);
    chk("rst.fc", FlushCount, 0);
    tick(); tick();
    reset = 0;

    // Load-use on Rn stalls one cycle.
    set_load_use(5'd3);
    mid(); ctrl("lu", 0, 0, 1, 0, 0);
    tick(); chk("lu.sc", StallCount, 1);
    clr();
    mid(); ctrl("lu.after", 1, 1, 0, 0, 0);

    // Zero register never stalls.
    tick(); set_load_use(5'd31);
    mid(); ctrl("xzr", 1, 1, 0, 0, 0);
    tick(); chk("xzr.sc", StallCount, 1);

    // Match on Rn but Rn not read: no stall.
    clr(); set_load_use(5'd9); DecUsesRn = 0;
    mid(); chk("nouse.bub", IdExBubble, 0);
    // Rm path.
    tick(); clr(); ExMemRead = 1; ExRegWrite = 1; ExRd = 7; DecRm = 7; DecUsesRm = 1;
    mid(); chk("rm.bub", IdExBubble, 1);
    tick(); chk("rm.sc", StallCount, 2);
    // Not a register write: no stall.
    ExRegWrite = 0;
    mid(); chk("nowr.bub", IdExBubble, 0);

    // Flag hazard.
    tick(); clr(); DecFlagRead = 1; ExFlagWrite = 1;
    mid(); ctrl("flag", 0, 0, 1, 0, 0);
    tick(); chk("flag.sc", StallCount, 3);

    // Taken branch beats load-use; next cycle FLUSH suppresses the stall.
    clr(); set_load_use(5'd4); MemBrTaken = 1;
    mid(); ctrl("br", 1, 1, 0, 1, 0);
    tick(); chk("br.fc", FlushCount, 1);
    MemBrTaken = 0;
    mid(); ctrl("br.flush", 1, 1, 0, 0, 0);
    tick(); chk("br.sc", StallCount, 3);
    mid(); ctrl("br.run", 0, 0, 1, 0, 0);
    tick(); chk("br.sc2", StallCount, 4);

    // Freeze for 3 cycles with a held taken branch, flush on the fourth.
    clr(); MemBusy = 1; MemBrTaken = 1;
    for (int i = 0; i < 3; i++) begin
      mid(); ctrl($sformatf("fz%0d", i), 0, 0, 0, 0, 1);
      tick();
    end
    chk("fz.fc", FlushCount, 1);
    MemBusy = 0;
    mid(); ctrl("fz.rel", 1, 1, 0, 1, 0);
    tick(); chk("fz.fc2", FlushCount, 2);
    MemBrTaken = 0;
    mid(); ctrl("fz.flush", 1, 1, 0, 0, 0);
    tick();

    // Saturate the stall counter.
    exp_stall = 4;
    set_load_use(5'd2);
    while (exp_stall < 65535) begin
      tick(); exp_stall++;
    end
    chk("sat.pre", StallCount, 65535);
    mid(); chk("sat.bub", IdExBubble, 1);
    tick(); chk("sat.post", StallCount, 65535);

    // Reset between edges during FREEZE.
    clr(); MemBusy = 1;
    tick();
    mid(); chk("rf.fz", Freeze, 1);
    #2 reset = 1;
    #1;
    ctrl("rf.rst", 0, 0, 0, 1, 0);
    chk("rf.sc", StallCount, 0);
    chk("rf.fc", FlushCount, 0);
    tick(); reset = 0; MemBusy = 0;
    mid(); ctrl("rf.run", 1, 1, 0, 0, 0);
    chk("rf.sc2", StallCount, 0);

    // Reset mid-flush: first cycle after release is RUN, so load-use stalls.
    tick(); MemBrTaken = 1;
    tick(); MemBrTaken = 0;
    mid(); chk("rfl.inflush", Flush, 0);
    #2 reset = 1;
    tick(); reset = 0; set_load_use(5'd6);
    mid(); ctrl("rfl.run", 0, 0, 1, 0, 0);
    tick(); chk("rfl.sc", StallCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of each performance counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high.
REQ-004 SHALL have port: DecRn  input  5  first source register of the decode-stage instruction.
REQ-005 SHALL have port: DecRm  input  5  second source register of the decode-stage instruction.
REQ-006 SHALL have port: DecUsesRn, DecUsesRm  input  1 each  source actually read.
REQ-007 SHALL have port: DecFlagRead  input  1  decode instruction is a conditional branch reading flags.
REQ-008 SHALL have port: ExRd  input  5  destination register in execute.
REQ-009 SHALL have port: ExMemRead, ExRegWrite, ExFlagWrite  input  1 each  execute-stage controls.
REQ-010 SHALL have port: MemBrTaken  input  1  branch resolved taken in the memory stage.
REQ-011 SHALL have port: MemBusy  input  1  data memory not ready.
REQ-012 SHALL have port: PcWrite  output  1  PC may update.
REQ-013 SHALL have port: IfIdWrite  output  1  fetch/decode register may load.
REQ-014 SHALL have port: IdExBubble  output  1  load zeros into decode/execute controls.
REQ-015 SHALL have port: Flush  output  1  clear fetch/decode, decode/execute and execute/memory registers.
REQ-016 SHALL have port: Freeze  output  1  hold every pipeline register.
REQ-017 SHALL have port: StallCount, FlushCount  output  CNT_W each  performance counters.

Function
REQ-018 SHALL implement FSM states RUN, FLUSH and FREEZE; outputs are Mealy (state plus current inputs).
REQ-019 SHALL evaluate causes in priority order: MemBusy, then MemBrTaken, then load-use, then flag hazard.
REQ-020 SHALL, while MemBusy=1 in any state, drive Freeze=1, PcWrite=0, IfIdWrite=0, IdExBubble=0, Flush=0 and go to FREEZE.
REQ-021 SHALL, in FREEZE with MemBusy=0, act as RUN in that cycle.
REQ-022 SHALL, in FREEZE with MemBusy=0, go to FLUSH if MemBrTaken=1.
REQ-023 SHALL, in FREEZE with MemBusy=0, go to RUN if MemBrTaken=0.
REQ-024 SHALL defer a MemBrTaken that coincides with MemBusy until the first cycle with MemBusy=0; MemBrTaken is held because the memory stage is frozen.
REQ-025 SHALL, in RUN with MemBrTaken=1 and MemBusy=0, drive Flush=1, PcWrite=1, IfIdWrite=1, IdExBubble=0 and go to FLUSH.
REQ-026 SHALL, in FLUSH, suppress load-use and flag detection (decode holds a bubble).
REQ-027 SHALL, in FLUSH, drive PcWrite=1, IfIdWrite=1, Flush=0.
REQ-028 SHALL, in FLUSH, return to RUN after exactly one cycle unless MemBusy=1.
REQ-029 SHALL detect load-use when ExMemRead & ExRegWrite & ExRd!=31 & ((DecUsesRn & DecRn==ExRd) | (DecUsesRm & DecRm==ExRd)).
REQ-030 SHALL detect a flag hazard when DecFlagRead & ExFlagWrite.
REQ-031 SHALL, on either hazard in RUN, drive PcWrite=0, IfIdWrite=0, IdExBubble=1 for that cycle only and stay in RUN.
REQ-032 SHALL, in RUN with no cause, drive PcWrite=1, IfIdWrite=1, IdExBubble=0, Flush=0, Freeze=0.
REQ-033 SHALL increment StallCount on each edge with IdExBubble=1, saturating at all-ones.
REQ-034 SHALL increment FlushCount on each edge with Flush=1, saturating at all-ones.

Reset
REQ-035 SHALL, while reset=1, force state RUN and StallCount=FlushCount=0.
REQ-036 SHALL, while reset=1, drive PcWrite=0, IfIdWrite=0, IdExBubble=0, Flush=1, Freeze=0.
REQ-037 SHALL, when reset asserts mid-stall, mid-flush or mid-freeze, abandon it immediately; the first cycle after release is RUN.

Structure
REQ-038 SHALL take the state enum, the XZR constant (31) and the CNT_W default from shared package pipeline_ctrl_pkg.
REQ-039 SHALL place the load-use/flag comparison in one combinational sub-module hazard_detect; the FSM and counters remain in pipeline_hazard_ctrl.

Verification
REQ-040 SHALL cover: ExMemRead=1, ExRegWrite=1, ExRd=3, DecRn=3, DecUsesRn=1 -> one cycle PcWrite=0, IdExBubble=1; StallCount 0->1.
REQ-041 SHALL cover: the same with ExRd=31 -> no stall; StallCount unchanged.
REQ-042 SHALL cover: MemBrTaken=1 for one cycle while a load-use is present -> Flush=1, IdExBubble=0; next cycle FLUSH with no stall; FlushCount=1.
REQ-043 SHALL cover: MemBusy=1 for 3 cycles with MemBrTaken=1 -> Freeze=1 for 3 cycles, Flush=0; fourth cycle Flush=1.
REQ-044 SHALL cover: StallCount preset by 65535 stalls, then one more stall -> stays 65535.
REQ-045 SHALL cover: reset asserted between clock edges during FREEZE -> outputs take reset values without a clock edge; after release, RUN with counters 0.
